huffman_scheduler: RTL and testbench



---
 rtl/huffman_pkg.sv | 28 ++
 rtl/huffman_min2_scan.sv | 64 ++++++
 rtl/huffman_scheduler.sv | 174 +++++++++++++++++
 tb/tb_huffman_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman scheduler: node ids, the sequencer
// state encoding and the (count, id) ordering used to pick merge candidates.
package huffman_pkg;

    localparam int unsigned SYM_NUM  = 6;
    localparam int unsigned NODE_NUM = 11;
    localparam int unsigned NODE_W   = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned KEY_CW   = 16;

    typedef logic [NODE_W-1:0] node_id_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_SCAN,
        S_WRITE,
        S_WAIT,
        S_FIN
    } state_t;

    // Strict ordering on {count, id}: equal counts resolve to the lower id.
    function automatic logic key_lt(input logic [KEY_CW-1:0] cnt_a, input node_id_t id_a,
                                    input logic [KEY_CW-1:0] cnt_b, input node_id_t id_b);
        return {cnt_a, id_a} < {cnt_b, id_b};
    endfunction

endpackage

// File: rtl/huffman_min2_scan.sv
// Registered tracker of the two smallest (count, id) keys seen since i_start.
// i_start empties the tracker in the same cycle its candidate is considered.
module huffman_min2_scan
    import huffman_pkg::*;
#(
    parameter int unsigned CW = CNT_W + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_start,
    input  logic          i_cand_valid,
    input  node_id_t      i_cand_id,
    input  logic [CW-1:0] i_cand_cnt,
    output node_id_t      o_min1_id,
    output node_id_t      o_min2_id
);

    logic          r_min1_vld, r_min2_vld;
    node_id_t      r_min1_id, r_min2_id;
    logic [CW-1:0] r_min1_cnt, r_min2_cnt;
    logic          w_m1v, w_m2v, w_lt1, w_lt2;

    always_comb begin
        w_m1v = r_min1_vld && !i_start;
        w_m2v = r_min2_vld && !i_start;
        w_lt1 = !w_m1v || key_lt(KEY_CW'(i_cand_cnt), i_cand_id, KEY_CW'(r_min1_cnt), r_min1_id);
        w_lt2 = !w_m2v || key_lt(KEY_CW'(i_cand_cnt), i_cand_id, KEY_CW'(r_min2_cnt), r_min2_id);
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_min1_vld <= 1'b0;
            r_min2_vld <= 1'b0;
            r_min1_id  <= '0;
            r_min2_id  <= '0;
            r_min1_cnt <= '0;
            r_min2_cnt <= '0;
        end else begin
            if (i_start) begin
                r_min1_vld <= 1'b0;
                r_min2_vld <= 1'b0;
            end
            if (i_cand_valid) begin
                if (w_lt1) begin
                    r_min2_vld <= w_m1v;
                    r_min2_id  <= r_min1_id;
                    r_min2_cnt <= r_min1_cnt;
                    r_min1_vld <= 1'b1;
                    r_min1_id  <= i_cand_id;
                    r_min1_cnt <= i_cand_cnt;
                end else if (w_lt2) begin
                    r_min2_vld <= 1'b1;
                    r_min2_id  <= i_cand_id;
                    r_min2_cnt <= i_cand_cnt;
                end
            end
        end
    end

    assign o_min1_id = r_min1_id;
    assign o_min2_id = r_min2_id;

endmodule

// File: rtl/huffman_scheduler.sv
// Huffman flow sequencer: symbol counting, five tree-merge rounds, sender handshake.
// Define HUFF_CNT_SAT_EN to saturate symbol counts instead of wrapping them.
module huffman_scheduler
    import huffman_pkg::*;
#(
    parameter int unsigned CNT_W = huffman_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gray_valid,
    input  logic [7:0]       gray_data,
    input  logic             sender_done,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2,
    output logic [CNT_W-1:0] CNT3,
    output logic [CNT_W-1:0] CNT4,
    output logic [CNT_W-1:0] CNT5,
    output logic [CNT_W-1:0] CNT6,
    output logic             CNT_valid,
    output logic [3:0]       tree_0_0,
    output logic [3:0]       tree_0_1,
    output logic [3:0]       tree_0_2,
    output logic [3:0]       tree_0_3,
    output logic [3:0]       tree_0_4,
    output logic [3:0]       tree_1_0,
    output logic [3:0]       tree_1_1,
    output logic [3:0]       tree_1_2,
    output logic [3:0]       tree_1_3,
    output logic [3:0]       tree_1_4,
    output logic             tree_done,
    output logic             code_valid
);

    localparam int unsigned NCW = CNT_W + 1;

    state_t               r_state;
    logic [2:0]           r_round;
    node_id_t             r_idx;
    logic [NCW-1:0]       r_cnt [NODE_NUM];
    logic [NODE_NUM-1:0]  r_act;
    node_id_t             r_t0 [5];
    node_id_t             r_t1 [5];
    logic [CNT_W-1:0]     r_cnt_out [SYM_NUM];

    logic                 w_sym_vld;
    node_id_t             w_sym;
    logic [CNT_W-1:0]     w_leaf, w_leaf_nx;
    logic                 w_cand_valid, w_start, w_last;
    node_id_t             w_min1, w_min2, w_new;
    logic [NCW-1:0]       w_sum;

    always_comb begin
        w_sym_vld    = (gray_data >= 8'd1) && (gray_data <= 8'd6);
        w_sym        = gray_data[3:0] - 4'd1;
        w_leaf       = r_cnt[w_sym][CNT_W-1:0];
`ifdef HUFF_CNT_SAT_EN
        w_leaf_nx    = (&w_leaf) ? w_leaf : w_leaf + CNT_W'(1);
`else
        w_leaf_nx    = w_leaf + CNT_W'(1);
`endif
        w_cand_valid = (r_state == S_SCAN) && r_act[r_idx];
        w_start      = (r_state == S_SCAN) && (r_idx == '0);
        w_last       = (r_idx == ({1'b0, r_round} + 4'd5));
        w_new        = {1'b0, r_round} + 4'd6;
        w_sum        = r_cnt[w_min1] + r_cnt[w_min2];
    end

    huffman_min2_scan #(
        .CW (NCW)
    ) u_scan (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (r_state == S_IDLE),
        .i_start      (w_start),
        .i_cand_valid (w_cand_valid),
        .i_cand_id    (r_idx),
        .i_cand_cnt   (r_cnt[r_idx]),
        .o_min1_id    (w_min1),
        .o_min2_id    (w_min2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_round    <= '0;
            r_idx      <= '0;
            r_act      <= '0;
            CNT_valid  <= 1'b0;
            tree_done  <= 1'b0;
            code_valid <= 1'b0;
            for (int unsigned i = 0; i < NODE_NUM; i++) r_cnt[i] <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                r_t0[i] <= '0;
                r_t1[i] <= '0;
            end
            for (int unsigned i = 0; i < SYM_NUM; i++) r_cnt_out[i] <= '0;
        end else begin
            CNT_valid  <= 1'b0;
            code_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    tree_done <= 1'b0;
                    // Clearing and counting the stream's first sample share this edge.
                    for (int unsigned i = 0; i < NODE_NUM; i++) begin
                        r_cnt[i] <= (gray_valid && w_sym_vld && (w_sym == node_id_t'(i))) ? NCW'(1) : '0;
                        r_act[i] <= (i < SYM_NUM);
                    end
                    if (gray_valid) r_state <= S_COUNT;
                end
                S_COUNT: begin
                    if (gray_valid) begin
                        if (w_sym_vld) r_cnt[w_sym] <= {1'b0, w_leaf_nx};
                    end else begin
                        r_state   <= S_SCAN;
                        r_round   <= '0;
                        r_idx     <= '0;
                        CNT_valid <= 1'b1;
                        for (int unsigned i = 0; i < SYM_NUM; i++) r_cnt_out[i] <= r_cnt[i][CNT_W-1:0];
                    end
                end
                S_SCAN: begin
                    if (w_last) r_state <= S_WRITE;
                    else        r_idx   <= r_idx + 4'd1;
                end
                S_WRITE: begin
                    r_t1[r_round]  <= w_min1;
                    r_t0[r_round]  <= w_min2;
                    r_cnt[w_new]   <= w_sum;
                    r_act[w_min1]  <= 1'b0;
                    r_act[w_min2]  <= 1'b0;
                    r_act[w_new]   <= 1'b1;
                    r_idx          <= '0;
                    if (r_round == 3'd4) begin
                        r_state   <= S_WAIT;
                        tree_done <= 1'b1;
                    end else begin
                        r_round <= r_round + 3'd1;
                        r_state <= S_SCAN;
                    end
                end
                S_WAIT: begin
                    if (sender_done) begin
                        r_state    <= S_FIN;
                        tree_done  <= 1'b0;
                        code_valid <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CNT1 = r_cnt_out[0];
    assign CNT2 = r_cnt_out[1];
    assign CNT3 = r_cnt_out[2];
    assign CNT4 = r_cnt_out[3];
    assign CNT5 = r_cnt_out[4];
    assign CNT6 = r_cnt_out[5];

    assign tree_0_0 = r_t0[0];
    assign tree_0_1 = r_t0[1];
    assign tree_0_2 = r_t0[2];
    assign tree_0_3 = r_t0[3];
    assign tree_0_4 = r_t0[4];
    assign tree_1_0 = r_t1[0];
    assign tree_1_1 = r_t1[1];
    assign tree_1_2 = r_t1[2];
    assign tree_1_3 = r_t1[3];
    assign tree_1_4 = r_t1[4];

endmodule

// File: tb/tb_huffman_scheduler.sv
// Randomized self-checking bench for huffman_scheduler against a behavioural
// count-and-merge reference model.
module tb_huffman_scheduler;

    logic       clk = 1'b0;
    logic       reset, gray_valid, sender_done;
    logic [7:0] gray_data;
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
    logic       CNT_valid, tree_done, code_valid;
    logic [3:0] tree_0_0, tree_0_1, tree_0_2, tree_0_3, tree_0_4;
    logic [3:0] tree_1_0, tree_1_1, tree_1_2, tree_1_3, tree_1_4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned stim [$];
    int unsigned m_cnt [6];
    int unsigned m_t0 [5];
    int unsigned m_t1 [5];

    logic [3:0] t0 [5];
    logic [3:0] t1 [5];
    logic [7:0] cnts [6];

    always #5 clk = ~clk;

    huffman_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .sender_done(sender_done),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3), .CNT4(CNT4), .CNT5(CNT5), .CNT6(CNT6),
        .CNT_valid(CNT_valid),
        .tree_0_0(tree_0_0), .tree_0_1(tree_0_1), .tree_0_2(tree_0_2), .tree_0_3(tree_0_3), .tree_0_4(tree_0_4),
        .tree_1_0(tree_1_0), .tree_1_1(tree_1_1), .tree_1_2(tree_1_2), .tree_1_3(tree_1_3), .tree_1_4(tree_1_4),
        .tree_done(tree_done), .code_valid(code_valid)
    );

    assign t0[0] = tree_0_0; assign t0[1] = tree_0_1; assign t0[2] = tree_0_2;
    assign t0[3] = tree_0_3; assign t0[4] = tree_0_4;
    assign t1[0] = tree_1_0; assign t1[1] = tree_1_1; assign t1[2] = tree_1_2;
    assign t1[3] = tree_1_3; assign t1[4] = tree_1_4;
    assign cnts[0] = CNT1; assign cnts[1] = CNT2; assign cnts[2] = CNT3;
    assign cnts[3] = CNT4; assign cnts[4] = CNT5; assign cnts[5] = CNT6;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned out_sum();
        int unsigned s;
        s = int'(CNT_valid) + int'(tree_done) + int'(code_valid);
        for (int i = 0; i < 6; i++) s += int'(cnts[i]);
        for (int i = 0; i < 5; i++) s += int'(t0[i]) + int'(t1[i]);
        return s;
    endfunction

    // Reference: occurrence counts, then repeatedly merge the two lowest
    // (count, id) live nodes; scanning ids upward with strict < keeps the lower id on ties.
    task automatic model_run();
        int unsigned occ [6];
        int unsigned nc [11];
        bit          live [11];
        int unsigned a, b;
        for (int i = 0; i < 6; i++) occ[i] = 0;
        foreach (stim[i]) if (stim[i] >= 1 && stim[i] <= 6) occ[stim[i] - 1]++;
        for (int i = 0; i < 11; i++) begin
            live[i] = 1'b0;
            nc[i]   = 0;
        end
        for (int i = 0; i < 6; i++) begin
`ifdef HUFF_CNT_SAT_EN
            m_cnt[i] = (occ[i] > 255) ? 255 : occ[i];
`else
            m_cnt[i] = occ[i] % 256;
`endif
            nc[i]   = m_cnt[i];
            live[i] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            a = 99;
            for (int id = 0; id < 11; id++) if (live[id] && (a == 99 || nc[id] < nc[a])) a = id;
            live[a] = 1'b0;
            b = 99;
            for (int id = 0; id < 11; id++) if (live[id] && (b == 99 || nc[id] < nc[b])) b = id;
            live[b] = 1'b0;
            m_t1[k] = a;
            m_t0[k] = b;
            nc[6 + k]   = nc[a] + nc[b];
            live[6 + k] = 1'b1;
        end
    endtask

    // abort: 0 none, 1 reset during merge round 2, 2 reset while waiting in WAIT
    task automatic run_stream(input bit sd_in_scan, input int unsigned abort);
        int unsigned cyc, pulses, hold;
        bit          aborted;
        model_run();
        foreach (stim[i]) begin
            gray_valid = 1'b1;
            gray_data  = 8'(stim[i]);
            @(negedge clk);
        end
        gray_valid = 1'b0;
        gray_data  = 8'($urandom);
        @(negedge clk);
        check("cnt_valid_rise", int'(CNT_valid), 1);
        for (int i = 0; i < 6; i++) check($sformatf("cnt%0d", i + 1), int'(cnts[i]), m_cnt[i]);
        cyc = 0; pulses = 1; aborted = 1'b0;
        while (!tree_done && cyc < 200 && !aborted) begin
            gray_valid  = 1'($urandom_range(0, 1));
            gray_data   = 8'($urandom);
            sender_done = sd_in_scan && (cyc == 12 || cyc == 30);
            if (abort == 1 && cyc == 18) begin
                reset = 1'b1;
                @(negedge clk);
                check("reset_mid_scan_outputs", out_sum(), 0);
                reset = 1'b0; gray_valid = 1'b0; sender_done = 1'b0;
                @(negedge clk);
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
                pulses += int'(CNT_valid);
                check("code_valid_early", int'(code_valid), 0);
            end
        end
        gray_valid  = 1'b0;
        sender_done = 1'b0;
        if (!aborted) begin
            check("tree_done_latency", cyc, 45);
            check("cnt_valid_pulses", pulses, 1);
            for (int k = 0; k < 5; k++) begin
                check($sformatf("tree_1_%0d", k), int'(t1[k]), m_t1[k]);
                check($sformatf("tree_0_%0d", k), int'(t0[k]), m_t0[k]);
            end
            hold = $urandom_range(1, 4);
            repeat (hold) begin
                @(negedge clk);
                check("tree_done_hold", int'(tree_done), 1);
                check("cnt1_hold", int'(CNT1), m_cnt[0]);
            end
            if (abort == 2) begin
                reset = 1'b1;
                @(negedge clk);
                check("reset_in_wait_outputs", out_sum(), 0);
                reset = 1'b0;
                @(negedge clk);
            end else begin
                sender_done = 1'b1;
                @(negedge clk);
                sender_done = 1'b0;
                check("code_valid_pulse", int'(code_valid), 1);
                check("tree_done_fin", int'(tree_done), 0);
                @(negedge clk);
                check("code_valid_end", int'(code_valid), 0);
                check("tree_done_idle", int'(tree_done), 0);
            end
        end
    endtask

    task automatic gen_random(input int unsigned len);
        stim.delete();
        for (int unsigned i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) stim.push_back($urandom_range(7, 255));
            else                            stim.push_back($urandom_range(0, 6));
        end
    endtask

    initial begin
        int unsigned plan_cnt [6];
        int unsigned plan_t1 [5];
        int unsigned plan_t0 [5];
        int unsigned tmp, j;
        int unsigned saved [$];
        plan_cnt = '{30, 10, 20, 5, 25, 10};
        plan_t1  = '{3, 5, 2, 7, 8};
        plan_t0  = '{1, 6, 4, 0, 9};

        reset = 1'b1; gray_valid = 1'b0; gray_data = '0; sender_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_sum(), 0);
        reset = 1'b0;
        @(negedge clk);

        // Worked example, shuffled, with invalid values 0 and 7 mixed in.
        stim.delete();
        for (int s = 0; s < 6; s++) repeat (plan_cnt[s]) stim.push_back(s + 1);
        for (int i = stim.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = stim[i]; stim[i] = stim[j]; stim[j] = tmp;
        end
        for (int i = 0; i < 12; i++) stim.insert($urandom_range(stim.size() - 1, 1), (i % 2) ? 7 : 0);
        run_stream(1'b1, 0);
        for (int i = 0; i < 6; i++) check($sformatf("plan_cnt%0d", i + 1), int'(cnts[i]), plan_cnt[i]);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("plan_tree_1_%0d", k), int'(t1[k]), plan_t1[k]);
            check($sformatf("plan_tree_0_%0d", k), int'(t0[k]), plan_t0[k]);
        end

        // All samples equal to 4: every leaf but one ties at zero.
        stim.delete();
        repeat (100) stim.push_back(4);
        run_stream(1'b0, 0);
        check("all4_cnt4", int'(CNT4), 100);
        check("all4_tree_1_0", int'(tree_1_0), 0);
        check("all4_tree_0_0", int'(tree_0_0), 1);

        for (int r = 0; r < 5; r++) begin
            gen_random($urandom_range(1, 60));
            run_stream(1'($urandom_range(0, 1)), 0);
        end

        // Abort mid-merge, then replay the same stream cleanly.
        gen_random(40);
        saved = stim;
        run_stream(1'b0, 1);
        stim = saved;
        run_stream(1'b0, 0);

        stim.delete();
        repeat (300) stim.push_back(1);
        run_stream(1'b0, 0);
`ifdef HUFF_CNT_SAT_EN
        check("sat_cnt1", int'(CNT1), 255);
`else
        check("wrap_cnt1", int'(CNT1), 44);
`endif

        gen_random(25);
        run_stream(1'b0, 2);
        gen_random(30);
        run_stream(1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
